data_memory_bank: RTL and testbench
===================================

# data_memory_bank

Latency-modelling data memory that sits directly downstream of the memory controller and serves its per-channel read and write requests. Each channel runs an independent request state machine over one shared storage array. Each channel returns a one-cycle `ready` pulse after a programmable latency, then waits for the controller to drop `valid` before it accepts the next request. A side-band init port preloads contents for kernels and benches.

## Interface
- `ADDR_BITS`, 8: address width; the array holds 2^ADDR_BITS words.
- `DATA_BITS`, 16: word width.
- `NUM_CHANNELS`, 1: number of independent request channels.
- `READ_LATENCY`, 2: cycles from request acceptance to read `ready`; legal range ≥1.
- `WRITE_LATENCY`, 2: cycles from request acceptance to write `ready`; legal range ≥1.
- `clk` in, 1: single clock; all logic is on the rising edge.
- `reset` in, 1: asynchronous, active-low; 0 = reset.
- `mem_read_valid` in, NUM_CHANNELS: per-channel read request, level-held until served.
- `mem_read_address` in, ADDR_BITS × NUM_CHANNELS: read address per channel.
- `mem_read_ready` out, NUM_CHANNELS: one-cycle read completion pulse.
- `mem_read_data` out, DATA_BITS × NUM_CHANNELS: read data, valid while `ready` is high and held until the next read completes.
- `mem_write_valid` in, NUM_CHANNELS: per-channel write request, level-held.
- `mem_write_address` in, ADDR_BITS × NUM_CHANNELS: write address per channel.
- `mem_write_data` in, DATA_BITS × NUM_CHANNELS: write data per channel.
- `mem_write_ready` out, NUM_CHANNELS: one-cycle write completion pulse.
- `init_valid` in, 1: preload write strobe.
- `init_address` in, ADDR_BITS: preload address.
- `init_data` in, DATA_BITS: preload data.

## Operation
- Each channel runs a four-state FSM: IDLE, BUSY, RESPOND, DRAIN.
  - IDLE: if `mem_read_valid[i]` is high, latch the address, set `op = read`, load the counter with READ_LATENCY−1, and go to BUSY. Otherwise, if `mem_write_valid[i]` is high, latch address and data, set `op = write`, load the counter with WRITE_LATENCY−1, and go to BUSY. A read takes priority when both are high.
  - BUSY: decrement the counter. When the counter is 0, complete the request and go to RESPOND.
    - Read completion: register `array[addr]` into `mem_read_data[i]` and set `mem_read_ready[i]` to 1.
    - Write completion: commit `array[addr] <= data` and set `mem_write_ready[i]` to 1.
  - RESPOND: clear `ready`, then go to DRAIN.
  - DRAIN: stay until the valid signal of the latched op is low, then go to IDLE. This stops the still-high `valid` from being re-accepted as a new request.
- A request is latched at acceptance. Address or data changes after acceptance are ignored.
- Read data is sampled at completion from array contents before any write committed on the same edge (read-old).
- Simultaneous writes to the same address on one edge resolve by priority: `init` beats the highest channel index, which beats lower channel indices.
- `init_valid` writes on every edge where it is high, independent of the FSM state. It is never acknowledged.
- The array is not reset; its contents survive `reset`.
- Asserting `reset` at any time has the following effect:
  - All FSMs go to IDLE.
  - All `ready` outputs go to 0 and `mem_read_data` goes to 0.
  - An in-flight write is dropped with no commit.
  - After release, a still-high `valid` counts as a new request.

## Timing
- Reset values: `mem_read_ready = 0`, `mem_write_ready = 0`, `mem_read_data = 0`, all FSMs in IDLE.
- Request accepted at edge E → `ready` high during the cycle after edge E+L (L = the op's latency), for exactly one cycle.
- A write is visible to a later read from completion edge E+L onward.
- Protocol with the controller: it deasserts `valid` at the edge after it sees `ready`. The channel leaves DRAIN at the first edge that samples `valid` low, and the next request can be accepted on the following edge.
- Minimum channel turnaround is L + 3 cycles.
- Channels are fully independent. N channels can have N requests in flight concurrently.

## Test plan
- Preload via init: `array[0x10] = 0xBEEF`. Read 0x10 with L=2 → `mem_read_ready` pulses exactly 2 cycles after acceptance with data 0xBEEF, one cycle wide.
- Write 0x22 ← 0x1234 (L=3), then read 0x22 → write `ready` at +3 cycles, read returns 0x1234. With `valid` held high 2 extra cycles, no second `ready` is produced.
- Read and write valid together on channel 0 → read is served first. The write is served after `valid` drops and is re-presented.
- 2 channels write address 0x05 on the same completion edge, channel 0 = 0x1111 and channel 1 = 0x2222 → a read returns 0x2222. With `init` also writing 0x3333 on that edge → a read returns 0x3333.
- Read of 0x40 completing on the same edge as a write of 0x40 ← 0xAAAA on another channel → the read returns the old value; a subsequent read returns 0xAAAA.
- `reset` pulsed low mid-BUSY on a write to 0x30 → no `ready`, `array[0x30]` unchanged. After release with `valid` still high → the request is re-served with full latency.

Source files
------------

// File: rtl/data_memory_bank.sv
// data_memory_bank
// Latency-modelling data memory serving per-channel read/write requests from
// the memory controller. Each channel owns a small request FSM
// (IDLE -> BUSY -> RESPOND -> DRAIN) and all channels share one storage array.
// A side-band init port preloads words regardless of channel activity.
module data_memory_bank #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CHANNELS  = 1,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
    output logic [NUM_CHANNELS-1:0]           mem_read_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
    input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
    output logic [NUM_CHANNELS-1:0]           mem_write_ready,
    input  logic                              init_valid,
    input  logic [ADDR_BITS-1:0]              init_address,
    input  logic [DATA_BITS-1:0]              init_data
);

    localparam int DEPTH   = 1 << ADDR_BITS;
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    // The counter only ever holds latency-1, so clog2(MAX_LAT) bits suffice.
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESPOND = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    // Shared storage; deliberately never reset so contents survive reset.
    logic [DATA_BITS-1:0] mem [DEPTH];

    // Control state (reset)
    state_t               state_q    [NUM_CHANNELS];
    state_t               state_d    [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] rd_ready_q;
    logic [NUM_CHANNELS-1:0] rd_ready_d;
    logic [NUM_CHANNELS-1:0] wr_ready_q;
    logic [NUM_CHANNELS-1:0] wr_ready_d;
    logic [DATA_BITS-1:0] rd_data_q  [NUM_CHANNELS];
    logic [DATA_BITS-1:0] rd_data_d  [NUM_CHANNELS];

    // Latched request (not reset; only meaningful outside IDLE)
    logic [NUM_CHANNELS-1:0] op_wr_q;
    logic [NUM_CHANNELS-1:0] op_wr_d;
    logic [ADDR_BITS-1:0] addr_q     [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] addr_d     [NUM_CHANNELS];
    logic [DATA_BITS-1:0] wdata_q    [NUM_CHANNELS];
    logic [DATA_BITS-1:0] wdata_d    [NUM_CHANNELS];
    logic [CNT_W-1:0]     cnt_q      [NUM_CHANNELS];
    logic [CNT_W-1:0]     cnt_d      [NUM_CHANNELS];

    // Per-channel write commit strobe, asserted on the completion edge only
    logic [NUM_CHANNELS-1:0] wr_commit;

    // Next-state and completion logic for every channel FSM
    always_comb begin
        rd_ready_d = '0;
        wr_ready_d = '0;
        op_wr_d    = op_wr_q;
        wr_commit  = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            state_d[i]   = state_q[i];
            addr_d[i]    = addr_q[i];
            wdata_d[i]   = wdata_q[i];
            cnt_d[i]     = cnt_q[i];
            rd_data_d[i] = rd_data_q[i];
            unique case (state_q[i])
                ST_IDLE: begin
                    // Read wins when both requests are presented together.
                    if (mem_read_valid[i]) begin
                        op_wr_d[i]  = 1'b0;
                        addr_d[i]   = mem_read_address[i*ADDR_BITS +: ADDR_BITS];
                        cnt_d[i]    = CNT_W'(READ_LATENCY - 1);
                        state_d[i]  = ST_BUSY;
                    end else if (mem_write_valid[i]) begin
                        op_wr_d[i]  = 1'b1;
                        addr_d[i]   = mem_write_address[i*ADDR_BITS +: ADDR_BITS];
                        wdata_d[i]  = mem_write_data[i*DATA_BITS +: DATA_BITS];
                        cnt_d[i]    = CNT_W'(WRITE_LATENCY - 1);
                        state_d[i]  = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q[i] == '0) begin
                        state_d[i] = ST_RESPOND;
                        if (op_wr_q[i]) begin
                            wr_commit[i]  = 1'b1;
                            wr_ready_d[i] = 1'b1;
                        end else begin
                            // Sampled before any same-edge commit: read-old.
                            rd_data_d[i]  = mem[addr_q[i]];
                            rd_ready_d[i] = 1'b1;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end
                end
                ST_RESPOND: begin
                    // ready defaults low here, giving a single-cycle pulse.
                    state_d[i] = ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Wait out the still-high valid so it is not re-accepted.
                    if (op_wr_q[i] ? !mem_write_valid[i] : !mem_read_valid[i]) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase
        end
    end

    // Control registers: FSM state, ready pulses and read data return to zero on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ready_q <= '0;
            wr_ready_q <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state_q[i]   <= ST_IDLE;
                rd_data_q[i] <= '0;
            end
        end else begin
            rd_ready_q <= rd_ready_d;
            wr_ready_q <= wr_ready_d;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state_q[i]   <= state_d[i];
                rd_data_q[i] <= rd_data_d[i];
            end
        end
    end

    // Latched request fields; only consumed while the FSM is out of IDLE
    always_ff @(posedge clk) begin
        op_wr_q <= op_wr_d;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            addr_q[i]  <= addr_d[i];
            wdata_q[i] <= wdata_d[i];
            cnt_q[i]   <= cnt_d[i];
        end
    end

    // Array writes: later assignments win, so init beats the highest channel,
    // which beats lower channels, when they target the same word on one edge
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (wr_commit[i]) begin
                mem[addr_q[i]] <= wdata_q[i];
            end
        end
        if (init_valid) begin
            mem[init_address] <= init_data;
        end
    end

    // Flatten per-channel registers onto the output buses
    always_comb begin
        mem_read_ready  = rd_ready_q;
        mem_write_ready = wr_ready_q;
        mem_read_data   = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            mem_read_data[i*DATA_BITS +: DATA_BITS] = rd_data_q[i];
        end
    end

endmodule

// File: tb/tb_data_memory_bank.sv
// Self-checking bench for data_memory_bank: table-driven vectors, hand-written
// multi-cycle corner sequences and a randomized phase against a word-array model.
module tb_data_memory_bank;

    localparam int AB = 8;
    localparam int DB = 16;
    localparam int NC = 2;
    localparam int RL = 2;
    localparam int WL = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [NC-1:0]  rv, wv, rrdy, wrdy;
    logic [NC*AB-1:0] raddr, waddr;
    logic [NC*DB-1:0] wdata, rdata;
    logic           iv;
    logic [AB-1:0]  ia;
    logic [DB-1:0]  id;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: just the word array as the controller should see it.
    logic [DB-1:0] model_mem [256];

    typedef struct {
        bit            wr;
        int            ch;
        logic [AB-1:0] addr;
        logic [DB-1:0] data;
        logic [DB-1:0] exp_rd;
        int            exp_lat;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    data_memory_bank #(
        .ADDR_BITS    (AB),
        .DATA_BITS    (DB),
        .NUM_CHANNELS (NC),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_read_valid   (rv),
        .mem_read_address (raddr),
        .mem_read_ready   (rrdy),
        .mem_read_data    (rdata),
        .mem_write_valid  (wv),
        .mem_write_address(waddr),
        .mem_write_data   (wdata),
        .mem_write_ready  (wrdy),
        .init_valid       (iv),
        .init_address     (ia),
        .init_data        (id)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic init_write(input logic [AB-1:0] a, input logic [DB-1:0] d);
        iv = 1'b1;
        ia = a;
        id = d;
        tick();
        iv = 1'b0;
        model_mem[a] = d;
    endtask

    // One controller transaction: present, wait for ready, drop valid on the
    // following edge, then give DRAIN time to return to IDLE.
    task automatic xfer(input int ch, input bit wr, input logic [AB-1:0] a,
                        input logic [DB-1:0] d, output logic [DB-1:0] got, output int lat);
        int n;
        bit seen;
        if (wr) begin
            waddr[ch*AB +: AB] = a;
            wdata[ch*DB +: DB] = d;
            wv[ch] = 1'b1;
        end else begin
            raddr[ch*AB +: AB] = a;
            rv[ch] = 1'b1;
        end
        n = 0;
        seen = 1'b0;
        got = '0;
        lat = -1;
        while (!seen && n < 20) begin
            tick();
            n++;
            if ((wr ? wrdy[ch] : rrdy[ch]) === 1'b1) begin
                seen = 1'b1;
                lat = n - 1;
                got = rdata[ch*DB +: DB];
            end
        end
        tick();
        check("ready_one_cycle", {31'd0, (wr ? wrdy[ch] : rrdy[ch])}, 32'd0);
        if (wr) wv[ch] = 1'b0;
        else    rv[ch] = 1'b0;
        tick();
        tick();
        if (wr && seen) model_mem[a] = d;
    endtask

    task automatic dual_write(input bit with_init, input logic [DB-1:0] d0,
                              input logic [DB-1:0] d1, input logic [DB-1:0] di);
        int n;
        bit seen;
        logic [NC-1:0] rdy_at;
        logic [DB-1:0] got;
        int lat;
        waddr = {8'h05, 8'h05};
        wdata = {d1, d0};
        wv = 2'b11;
        n = 0;
        seen = 1'b0;
        rdy_at = '0;
        while (!seen && n < 20) begin
            if (with_init && n == WL) begin
                iv = 1'b1;
                ia = 8'h05;
                id = di;
            end
            tick();
            n++;
            iv = 1'b0;
            if (wrdy != '0) begin
                seen = 1'b1;
                rdy_at = wrdy;
            end
        end
        check("dual_both_ready", {30'd0, rdy_at}, 32'd3);
        check("dual_lat", n - 1, WL);
        tick();
        check("dual_ready_clear", {30'd0, wrdy}, 32'd0);
        wv = 2'b00;
        tick();
        tick();
        model_mem[8'h05] = d0;
        model_mem[8'h05] = d1;
        if (with_init) model_mem[8'h05] = di;
        xfer(0, 1'b0, 8'h05, '0, got, lat);
        check(with_init ? "dual_init_wins" : "dual_ch1_wins", got, model_mem[8'h05]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [DB-1:0] got;
        logic [DB-1:0] old;
        int lat;
        int n;
        bit seen;
        bit wr_early;
        int pulses;

        tbl[0] = '{1'b0, 0, 8'h10, 16'h0000, 16'hBEEF, RL};
        tbl[1] = '{1'b1, 0, 8'h22, 16'h1234, 16'h0000, WL};
        tbl[2] = '{1'b0, 1, 8'h22, 16'h0000, 16'h1234, RL};
        tbl[3] = '{1'b1, 1, 8'h80, 16'hCAFE, 16'h0000, WL};
        tbl[4] = '{1'b0, 0, 8'h80, 16'h0000, 16'hCAFE, RL};
        tbl[5] = '{1'b0, 1, 8'h10, 16'h0000, 16'hBEEF, RL};

        reset = 1'b0;
        rv = '0; wv = '0; raddr = '0; waddr = '0; wdata = '0;
        iv = 1'b0; ia = '0; id = '0;
        tick();
        tick();
        check("reset_rd_ready", {30'd0, rrdy}, 32'd0);
        check("reset_wr_ready", {30'd0, wrdy}, 32'd0);
        check("reset_rd_data", rdata, 32'd0);

        // Preload while held in reset: init does not depend on FSM state.
        for (int i = 0; i < 256; i++) begin
            init_write(AB'(i), DB'((i * 16'h0101) ^ 16'h5A5A));
        end
        init_write(8'h10, 16'hBEEF);
        reset = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 6; i++) begin
            xfer(tbl[i].ch, tbl[i].wr, tbl[i].addr, tbl[i].data, got, lat);
            check($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
            if (!tbl[i].wr) check($sformatf("vec%0d_data", i), got, {16'd0, tbl[i].exp_rd});
        end

        // Write with valid held well past ready: only one pulse.
        waddr[AB +: AB] = 8'h23;
        wdata[DB +: DB] = 16'h4321;
        wv[1] = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (wrdy[1] === 1'b1) pulses++;
        end
        check("held_valid_single_pulse", pulses, 1);
        wv[1] = 1'b0;
        tick();
        tick();
        model_mem[8'h23] = 16'h4321;
        xfer(0, 1'b0, 8'h23, '0, got, lat);
        check("held_valid_data", got, model_mem[8'h23]);

        // Read and write presented together: read first, write after read valid drops.
        raddr[0 +: AB] = 8'h10;
        waddr[0 +: AB] = 8'h50;
        wdata[0 +: DB] = 16'h7777;
        rv[0] = 1'b1;
        wv[0] = 1'b1;
        n = 0; seen = 1'b0; wr_early = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (rrdy[0] === 1'b1) seen = 1'b1;
            if (wrdy[0] === 1'b1) wr_early = 1'b1;
        end
        check("prio_rd_lat", n - 1, RL);
        check("prio_rd_data", rdata[0 +: DB], model_mem[8'h10]);
        tick();
        rv[0] = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (wrdy[0] === 1'b1) seen = 1'b1;
        end
        check("prio_wr_served", {31'd0, seen}, 32'd1);
        check("prio_wr_lat", n, WL + 2);
        check("prio_no_early_wr", {31'd0, wr_early}, 32'd0);
        tick();
        wv[0] = 1'b0;
        tick();
        tick();
        model_mem[8'h50] = 16'h7777;
        xfer(1, 1'b0, 8'h50, '0, got, lat);
        check("prio_wr_data", got, model_mem[8'h50]);

        // Same-address collisions on one completion edge.
        dual_write(1'b0, 16'h1111, 16'h2222, 16'h0000);
        dual_write(1'b1, 16'h1111, 16'h2222, 16'h3333);

        // Read and write of 0x40 completing on the same edge: read-old.
        old = model_mem[8'h40];
        waddr[AB +: AB] = 8'h40;
        wdata[DB +: DB] = 16'hAAAA;
        wv[1] = 1'b1;
        tick();
        raddr[0 +: AB] = 8'h40;
        rv[0] = 1'b1;
        tick();
        tick();
        tick();
        check("rw_edge_rd_ready", {31'd0, rrdy[0]}, 32'd1);
        check("rw_edge_wr_ready", {31'd0, wrdy[1]}, 32'd1);
        check("rw_edge_read_old", rdata[0 +: DB], old);
        tick();
        rv[0] = 1'b0;
        wv[1] = 1'b0;
        tick();
        tick();
        model_mem[8'h40] = 16'hAAAA;
        xfer(0, 1'b0, 8'h40, '0, got, lat);
        check("rw_edge_read_new", got, model_mem[8'h40]);

        // Reset mid-BUSY with valid dropped during reset: write is discarded.
        waddr[0 +: AB] = 8'h30;
        wdata[0 +: DB] = 16'h9999;
        wv[0] = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_mid_rd_data", rdata, 32'd0);
        wv[0] = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (wrdy[0] === 1'b1) pulses++;
        end
        check("rst_mid_no_ready", pulses, 0);
        reset = 1'b1;
        tick();
        tick();
        xfer(1, 1'b0, 8'h30, '0, got, lat);
        check("rst_mid_no_commit", got, model_mem[8'h30]);
        xfer(0, 1'b0, 8'h10, '0, got, lat);
        check("array_survives_reset", got, model_mem[8'h10]);

        // Reset mid-BUSY with valid held: re-served with full latency after release.
        wv[0] = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (wrdy[0] === 1'b1) seen = 1'b1;
        end
        check("rst_reserve_lat", n - 1, WL);
        tick();
        wv[0] = 1'b0;
        tick();
        tick();
        model_mem[8'h30] = 16'h9999;
        xfer(1, 1'b0, 8'h30, '0, got, lat);
        check("rst_reserve_data", got, model_mem[8'h30]);

        // Randomized transactions against the model.
        for (int k = 0; k < 40; k++) begin
            int ch;
            bit wr;
            logic [AB-1:0] a;
            logic [DB-1:0] d;
            logic [DB-1:0] exp;
            ch = int'($urandom_range(0, NC - 1));
            wr = 1'($urandom_range(0, 1));
            a  = {4'h6, 4'($urandom_range(0, 15))};
            d  = DB'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                init_write({4'h6, 4'($urandom_range(0, 15))}, DB'($urandom));
            end
            exp = model_mem[a];
            xfer(ch, wr, a, d, got, lat);
            check($sformatf("rand%0d_lat", k), lat, wr ? WL : RL);
            if (!wr) check($sformatf("rand%0d_data", k), got, exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
